// File: rtl/tjmono_pkg.sv
// Shared definitions for the TJ-Monopix hit assembler: record layout,
// assembler states, word tags and the ToT helper.
package tjmono_pkg;

    localparam int COL_W    = 6;
    localparam int ROW_W    = 9;
    localparam int EDGE_W   = 6;
    localparam int TS_W     = 52;
    localparam int TOKCNT_W = 32;
    localparam int REC_W    = 112;
    localparam int CHUNK_W  = 28;

    // Bit position of the possible-noise flag inside a 112-bit record
    localparam int NOISE_BIT = 27;

    // Assembler states: waiting for a tag-0 word, or collecting tags 1..3
    typedef enum logic {
        WAIT_HEAD = 1'b0,
        COLLECT   = 1'b1
    } state_e;

    // Sequence tags carried in word bits [29:28]
    localparam logic [1:0] TAG_HEAD = 2'd0;
    localparam logic [1:0] TAG_1    = 2'd1;
    localparam logic [1:0] TAG_LAST = 2'd3;

    // Record layout, MSB first, so a cast from the raw 112-bit record
    // lands each field at its fixed offset (col occupies bits [5:0]).
    typedef struct packed {
        logic [TOKCNT_W-1:0] token_cnt;  // [111:80]
        logic [TS_W-1:0]     timestamp;  // [79:28]
        logic                noise;      // [27]
        logic [EDGE_W-1:0]   le;         // [26:21]
        logic [EDGE_W-1:0]   te;         // [20:15]
        logic [ROW_W-1:0]    row;        // [14:6]
        logic [COL_W-1:0]    col;        // [5:0]
    } hit_rec_t;

    // Time over threshold: trailing minus leading edge, wrapping at 64
    function automatic logic [EDGE_W-1:0] tot_calc(input logic [EDGE_W-1:0] le,
                                                   input logic [EDGE_W-1:0] te);
        return te - le;
    endfunction

endpackage

// File: rtl/tjmono_hit_assembler_if.sv
// FIFO-side and hit-side handshake bundle of the hit assembler.
// master = the assembler, slave = the environment around it.
interface tjmono_hit_assembler_if;
    import tjmono_pkg::*;

    logic                FIFO_EMPTY;
    logic [31:0]         FIFO_DATA;
    logic                FIFO_READ;

    logic                HIT_VALID;
    logic                HIT_READY;
    logic [COL_W-1:0]    HIT_COL;
    logic [ROW_W-1:0]    HIT_ROW;
    logic [EDGE_W-1:0]   HIT_LE;
    logic [EDGE_W-1:0]   HIT_TE;
    logic [EDGE_W-1:0]   HIT_TOT;
    logic                HIT_NOISE;
    logic [TS_W-1:0]     HIT_TIMESTAMP;
    logic [TOKCNT_W-1:0] HIT_TOKEN_CNT;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, HIT_READY,
        output FIFO_READ, HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE,
               HIT_TOT, HIT_NOISE, HIT_TIMESTAMP, HIT_TOKEN_CNT
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DATA, HIT_READY,
        input  FIFO_READ, HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE,
               HIT_TOT, HIT_NOISE, HIT_TIMESTAMP, HIT_TOKEN_CNT
    );

endinterface

// File: rtl/tjmono_hit_assembler_sat_cnt8.sv
// 8-bit event counter that holds at 255 instead of wrapping.
module sat_cnt8 (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_r;

    // Count each inc pulse until the counter reaches all-ones
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            cnt_r <= 8'd0;
        end else if (inc && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/tjmono_hit_assembler.sv
// Rebuilds 112-bit TJ-Monopix hit records from four tagged 32-bit FIFO
// words, checks identifier and tag order, and hands each hit to the
// downstream consumer over a valid/ready handshake.
module tjmono_hit_assembler
    import tjmono_pkg::*;
#(
    parameter logic [1:0] IDENTIFIER = 2'b00
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    tjmono_hit_assembler_if.master   bus,
    input  logic                     CONF_EN,
    input  logic                     CONF_DROP_NOISE,
    output logic [7:0]               SEQ_ERR_CNT,
    output logic [7:0]               ID_ERR_CNT,
    output logic [7:0]               DROP_CNT
);

    logic [1:0]           tag_s;
    logic [CHUNK_W-1:0]   chunk_s;
    logic                 id_ok_s;
    logic                 completes_s;
    logic                 stall_s;
    logic                 pop_s;

    state_e               state_r;
    state_e               state_n_s;
    logic [1:0]           exp_idx_r;
    logic [1:0]           exp_idx_n_s;
    logic [3*CHUNK_W-1:0] asm_r;
    logic                 store_s;
    logic [1:0]           store_slot_s;
    logic                 seq_inc_s;
    logic                 id_inc_s;
    logic                 rec_done_s;
    logic [REC_W-1:0]     rec_s;
    logic                 load_s;
    logic                 drop_inc_s;

    logic                 hit_valid_r;
    hit_rec_t             hit_r;

    assign tag_s   = bus.FIFO_DATA[29:28];
    assign chunk_s = bus.FIFO_DATA[CHUNK_W-1:0];
    assign id_ok_s = (bus.FIFO_DATA[31:30] == IDENTIFIER);

    // The final word is only taken when the output register can accept it,
    // so a completed record is never lost while the consumer stalls.
    assign completes_s = (state_r == COLLECT) && (exp_idx_r == TAG_LAST) &&
                         (tag_s == TAG_LAST) && id_ok_s;
    assign stall_s     = completes_s && hit_valid_r && !bus.HIT_READY;
    assign pop_s       = CONF_EN && !bus.FIFO_EMPTY && !stall_s;

    // The tag-3 chunk comes straight from the FIFO head in its pop cycle
    assign rec_s      = {chunk_s, asm_r};
    assign load_s     = rec_done_s && !(rec_s[NOISE_BIT] && CONF_DROP_NOISE);
    assign drop_inc_s = rec_done_s && rec_s[NOISE_BIT] && CONF_DROP_NOISE;

    // Next-state, chunk-store and error-event decode for each popped word
    always_comb begin
        state_n_s    = state_r;
        exp_idx_n_s  = exp_idx_r;
        store_s      = 1'b0;
        store_slot_s = 2'd0;
        seq_inc_s    = 1'b0;
        id_inc_s     = 1'b0;
        rec_done_s   = 1'b0;
        if (!CONF_EN) begin
            state_n_s   = WAIT_HEAD;
            exp_idx_n_s = TAG_1;
        end else if (pop_s) begin
            if (!id_ok_s) begin
                id_inc_s    = 1'b1;
                state_n_s   = WAIT_HEAD;
                exp_idx_n_s = TAG_1;
            end else begin
                case (state_r)
                    WAIT_HEAD: begin
                        if (tag_s == TAG_HEAD) begin
                            store_s     = 1'b1;
                            exp_idx_n_s = TAG_1;
                            state_n_s   = COLLECT;
                        end else begin
                            seq_inc_s = 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (tag_s == exp_idx_r) begin
                            if (tag_s == TAG_LAST) begin
                                rec_done_s  = 1'b1;
                                state_n_s   = WAIT_HEAD;
                                exp_idx_n_s = TAG_1;
                            end else begin
                                store_s      = 1'b1;
                                store_slot_s = tag_s;
                                exp_idx_n_s  = exp_idx_r + 2'd1;
                            end
                        end else begin
                            seq_inc_s = 1'b1;
                            if (tag_s == TAG_HEAD) begin
                                store_s     = 1'b1;
                                exp_idx_n_s = TAG_1;
                            end else begin
                                state_n_s   = WAIT_HEAD;
                                exp_idx_n_s = TAG_1;
                            end
                        end
                    end
                    default: begin
                        state_n_s   = WAIT_HEAD;
                        exp_idx_n_s = TAG_1;
                    end
                endcase
            end
        end else begin
            state_n_s = state_r;
        end
    end

    // Assembler state and expected-tag register
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_r   <= WAIT_HEAD;
            exp_idx_r <= TAG_1;
        end else begin
            state_r   <= state_n_s;
            exp_idx_r <= exp_idx_n_s;
        end
    end

    // Holds chunks 0..2 of the record being assembled
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            asm_r <= {(3*CHUNK_W){1'b0}};
        end else if (store_s) begin
            case (store_slot_s)
                2'd0:    asm_r[CHUNK_W-1:0]           <= chunk_s;
                2'd1:    asm_r[2*CHUNK_W-1:CHUNK_W]   <= chunk_s;
                2'd2:    asm_r[3*CHUNK_W-1:2*CHUNK_W] <= chunk_s;
                default: asm_r                        <= asm_r;
            endcase
        end else begin
            asm_r <= asm_r;
        end
    end

    // Output register: load on completion, clear on handshake, else hold
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            hit_valid_r <= 1'b0;
            hit_r       <= hit_rec_t'({REC_W{1'b0}});
        end else if (load_s) begin
            hit_valid_r <= 1'b1;
            hit_r       <= hit_rec_t'(rec_s);
        end else if (hit_valid_r && bus.HIT_READY) begin
            hit_valid_r <= 1'b0;
            hit_r       <= hit_rec_t'({REC_W{1'b0}});
        end else begin
            hit_valid_r <= hit_valid_r;
            hit_r       <= hit_r;
        end
    end

    assign bus.FIFO_READ     = pop_s;
    assign bus.HIT_VALID     = hit_valid_r;
    assign bus.HIT_COL       = hit_r.col;
    assign bus.HIT_ROW       = hit_r.row;
    assign bus.HIT_LE        = hit_r.le;
    assign bus.HIT_TE        = hit_r.te;
    assign bus.HIT_TOT       = tot_calc(hit_r.le, hit_r.te);
    assign bus.HIT_NOISE     = hit_r.noise;
    assign bus.HIT_TIMESTAMP = hit_r.timestamp;
    assign bus.HIT_TOKEN_CNT = hit_r.token_cnt;

    sat_cnt8 u_seq_cnt  (.BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .inc(seq_inc_s),  .cnt(SEQ_ERR_CNT));
    sat_cnt8 u_id_cnt   (.BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .inc(id_inc_s),   .cnt(ID_ERR_CNT));
    sat_cnt8 u_drop_cnt (.BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .inc(drop_inc_s), .cnt(DROP_CNT));

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Self-checking bench for tjmono_hit_assembler: a queue-backed FWFT FIFO
// feeds tagged words, a record-level reference model predicts hits and
// error counts, and each scenario task compares the DUT against it.
`timescale 1ns/1ps
module tb_tjmono_hit_assembler;

    localparam logic [1:0] ID = 2'b01;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST = 1'b1;
    logic       CONF_EN = 1'b0;
    logic       CONF_DROP_NOISE = 1'b0;
    logic [7:0] SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT;

    tjmono_hit_assembler_if bus();

    tjmono_hit_assembler #(.IDENTIFIER(ID)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .bus(bus),
        .CONF_EN(CONF_EN), .CONF_DROP_NOISE(CONF_DROP_NOISE),
        .SEQ_ERR_CNT(SEQ_ERR_CNT), .ID_ERR_CNT(ID_ERR_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [31:0]  fifo_q[$];
    logic [27:0]  part_q[$];
    bit           in_rec;
    logic [111:0] exp_q[$];
    logic [111:0] obs_q[$];
    logic [5:0]   obs_tot_q[$];
    int           obs_cyc_q[$];
    int exp_seq, exp_id, exp_drop;
    int n_cmp, n_err;
    int cyc, last_pop_cyc, valid_cycles, rd_empty_viol;
    bit rand_ready;

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [111:0] make_rec(input int col, input int row, input int te, input int le,
                                              input bit noise, input logic [51:0] ts, input logic [31:0] tok);
        logic [5:0] c6, te6, le6;
        logic [8:0] r9;
        c6 = col[5:0]; r9 = row[8:0]; te6 = te[5:0]; le6 = le[5:0];
        return {tok, ts, noise, le6, te6, r9, c6};
    endfunction

    function automatic logic [111:0] rand_rec(input bit noise);
        logic [63:0] t;
        t = {$urandom, $urandom};
        return make_rec($urandom_range(0, 63), $urandom_range(0, 511), $urandom_range(0, 63),
                        $urandom_range(0, 63), noise, t[51:0], $urandom);
    endfunction

    function automatic logic [5:0] ref_tot(input logic [111:0] r);
        int d;
        d = (int'(r[20:15]) + 64 - int'(r[26:21])) % 64;
        return d[5:0];
    endfunction

    // Reference model: applies the tag/identifier rules word by word
    task automatic model_word(input logic [31:0] w);
        int tag;
        logic [111:0] rec;
        tag = int'(w[29:28]);
        if (w[31:30] != ID) begin
            exp_id = sat(exp_id); part_q.delete(); in_rec = 0;
        end else if (!in_rec) begin
            if (tag == 0) begin part_q.push_back(w[27:0]); in_rec = 1; end
            else exp_seq = sat(exp_seq);
        end else if (tag == part_q.size()) begin
            part_q.push_back(w[27:0]);
            if (part_q.size() == 4) begin
                rec = {part_q[3], part_q[2], part_q[1], part_q[0]};
                if (rec[27] && CONF_DROP_NOISE) exp_drop = sat(exp_drop);
                else exp_q.push_back(rec);
                part_q.delete(); in_rec = 0;
            end
        end else begin
            exp_seq = sat(exp_seq);
            part_q.delete();
            if (tag == 0) part_q.push_back(w[27:0]);
            else in_rec = 0;
        end
    endtask

    task automatic fifo_update();
        bus.FIFO_EMPTY = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) bus.FIFO_DATA = fifo_q[0];
        else bus.FIFO_DATA = 32'h0;
    endtask

    task automatic push_word(input logic [1:0] id, input logic [1:0] tag, input logic [27:0] chunk);
        logic [31:0] w;
        w = {id, tag, chunk};
        fifo_q.push_back(w);
        model_word(w);
        fifo_update();
    endtask

    task automatic push_rec(input logic [111:0] r);
        push_word(ID, 2'd0, r[27:0]);
        push_word(ID, 2'd1, r[55:28]);
        push_word(ID, 2'd2, r[83:56]);
        push_word(ID, 2'd3, r[111:84]);
    endtask

    task automatic clear_queues();
        exp_q.delete(); obs_q.delete(); obs_tot_q.delete(); obs_cyc_q.delete();
        valid_cycles = 0;
    endtask

    // One clock: sample at the falling edge, apply FIFO pops after the rising edge
    task automatic cycle();
        bit rd;
        if (rand_ready) bus.HIT_READY = ($urandom_range(0, 1) == 1);
        @(negedge BUS_CLK); #1;
        rd = bus.FIFO_READ;
        if (rd && bus.FIFO_EMPTY) rd_empty_viol++;
        if (bus.HIT_VALID) valid_cycles++;
        if (bus.HIT_VALID && bus.HIT_READY) begin
            obs_q.push_back({bus.HIT_TOKEN_CNT, bus.HIT_TIMESTAMP, bus.HIT_NOISE,
                             bus.HIT_LE, bus.HIT_TE, bus.HIT_ROW, bus.HIT_COL});
            obs_tot_q.push_back(bus.HIT_TOT);
            obs_cyc_q.push_back(cyc);
        end
        if (rd) last_pop_cyc = cyc;
        @(posedge BUS_CLK); #1;
        if (rd) begin void'(fifo_q.pop_front()); fifo_update(); end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || bus.HIT_VALID) && n < budget) begin cycle(); n++; end
        repeat (2) cycle();
        n_cmp++;
        if (n >= budget) begin n_err++; $display("FAIL drain_timeout after %0d cycles, fifo=%0d", n, fifo_q.size()); end
    endtask

    task automatic test_reset();
        BUS_RST = 1'b1; CONF_EN = 1'b0;
        repeat (3) @(posedge BUS_CLK);
        #1;
        n_cmp += 4;
        if (bus.HIT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.HIT_VALID); end
        if ({bus.HIT_TOKEN_CNT, bus.HIT_TIMESTAMP, bus.HIT_NOISE, bus.HIT_LE, bus.HIT_TE, bus.HIT_ROW, bus.HIT_COL, bus.HIT_TOT} !== 118'h0) begin
            n_err++; $display("FAIL reset_fields got nonzero hit fields");
        end
        if ({SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT} !== 24'h0) begin n_err++; $display("FAIL reset_counters got %h want 0", {SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT}); end
        if (bus.FIFO_READ !== 1'b0) begin n_err++; $display("FAIL reset_fifo_read got %b want 0", bus.FIFO_READ); end
        @(negedge BUS_CLK); BUS_RST = 1'b0;
        @(posedge BUS_CLK); #1;
        CONF_EN = 1'b1;
    endtask

    task automatic test_single();
        clear_queues(); bus.HIT_READY = 1'b1;
        push_rec(make_rec(5, 300, 20, 10, 1'b0, 52'h123456789ABCD, 32'd7));
        drain(50);
        n_cmp += 3;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
        else begin
            n_cmp += 2;
            if (obs_q[0] !== make_rec(5, 300, 20, 10, 1'b0, 52'h123456789ABCD, 32'd7)) begin n_err++; $display("FAIL single_rec got %h", obs_q[0]); end
            if (obs_cyc_q[0] != last_pop_cyc + 1) begin n_err++; $display("FAIL single_latency got cycle %0d want %0d", obs_cyc_q[0], last_pop_cyc + 1); end
            if (obs_tot_q[0] !== 6'd10) begin n_err++; $display("FAIL single_tot got %0d want 10", obs_tot_q[0]); end
        end
        if (valid_cycles != 1) begin n_err++; $display("FAIL single_pulse got %0d valid cycles want 1", valid_cycles); end
        if ({SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT} !== 24'h0) begin n_err++; $display("FAIL single_counters got %h want 0", {SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT}); end
    endtask

    task automatic test_backpressure();
        logic [111:0] cur;
        clear_queues(); bus.HIT_READY = 1'b0;
        push_rec(rand_rec(1'b0)); push_rec(rand_rec(1'b0));
        for (int k = 0; k < 2; k++) begin
            repeat (10) cycle();
            cur = {bus.HIT_TOKEN_CNT, bus.HIT_TIMESTAMP, bus.HIT_NOISE, bus.HIT_LE, bus.HIT_TE, bus.HIT_ROW, bus.HIT_COL};
            n_cmp += 4;
            if (fifo_q.size() != 1) begin n_err++; $display("FAIL bp_fifo_level got %0d want 1", fifo_q.size()); end
            if (bus.FIFO_READ !== 1'b0) begin n_err++; $display("FAIL bp_fifo_read got %b want 0", bus.FIFO_READ); end
            if (bus.HIT_VALID !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", bus.HIT_VALID); end
            if (cur !== exp_q[0]) begin n_err++; $display("FAIL bp_hold got %h want %h", cur, exp_q[0]); end
        end
        bus.HIT_READY = 1'b1;
        drain(50);
        n_cmp++;
        if (obs_q.size() != 2) begin n_err++; $display("FAIL bp_count got %0d want 2", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_rec[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_tag_error();
        logic [111:0] r1, r2;
        clear_queues(); bus.HIT_READY = 1'b1;
        r1 = rand_rec(1'b0); r2 = rand_rec(1'b0);
        push_word(ID, 2'd0, r1[27:0]); push_word(ID, 2'd1, r1[55:28]); push_word(ID, 2'd3, r1[111:84]);
        push_rec(r2);
        drain(50);
        n_cmp += 2;
        if (SEQ_ERR_CNT !== 8'd1) begin n_err++; $display("FAIL tag_seq1 got %0d want 1", SEQ_ERR_CNT); end
        if (obs_q.size() != 1 || obs_q[0] !== r2) begin n_err++; $display("FAIL tag_rec1 got %0d records want 1", obs_q.size()); end
        clear_queues();
        r1 = rand_rec(1'b0); r2 = rand_rec(1'b0);
        push_word(ID, 2'd0, r1[27:0]); push_word(ID, 2'd1, r1[55:28]);
        push_rec(r2);
        drain(50);
        n_cmp += 2;
        if (SEQ_ERR_CNT !== 8'd2) begin n_err++; $display("FAIL tag_seq2 got %0d want 2", SEQ_ERR_CNT); end
        if (obs_q.size() != 1 || obs_q[0] !== r2) begin n_err++; $display("FAIL tag_rec2 got %0d records want 1", obs_q.size()); end
    endtask

    task automatic test_id_error();
        logic [111:0] r1, r2;
        clear_queues(); bus.HIT_READY = 1'b1;
        r1 = rand_rec(1'b0); r2 = rand_rec(1'b0);
        push_word(ID, 2'd0, r1[27:0]); push_word(ID, 2'd1, r1[55:28]); push_word(2'b10, 2'd2, r1[83:56]);
        push_rec(r2);
        drain(50);
        n_cmp += 3;
        if (ID_ERR_CNT !== 8'd1) begin n_err++; $display("FAIL id_cnt got %0d want 1", ID_ERR_CNT); end
        if (SEQ_ERR_CNT !== 8'd2) begin n_err++; $display("FAIL id_seq got %0d want 2", SEQ_ERR_CNT); end
        if (obs_q.size() != 1 || obs_q[0] !== r2) begin n_err++; $display("FAIL id_rec got %0d records want 1", obs_q.size()); end
    endtask

    task automatic test_noise();
        logic [111:0] r;
        clear_queues(); bus.HIT_READY = 1'b1;
        r = rand_rec(1'b1);
        CONF_DROP_NOISE = 1'b1;
        push_rec(r);
        drain(50);
        n_cmp += 3;
        if (valid_cycles != 0) begin n_err++; $display("FAIL noise_drop_valid got %0d valid cycles want 0", valid_cycles); end
        if (DROP_CNT !== 8'd1) begin n_err++; $display("FAIL noise_drop_cnt got %0d want 1", DROP_CNT); end
        if (DROP_CNT !== 8'(exp_drop)) begin n_err++; $display("FAIL noise_model_cnt got %0d want %0d", DROP_CNT, exp_drop); end
        CONF_DROP_NOISE = 1'b0;
        push_rec(r);
        drain(50);
        n_cmp += 2;
        if (obs_q.size() != 1 || obs_q[0] !== r) begin n_err++; $display("FAIL noise_pass_rec got %0d records want 1", obs_q.size()); end
        if (obs_q.size() == 1 && obs_q[0][27] !== 1'b1) begin n_err++; $display("FAIL noise_flag got %b want 1", obs_q[0][27]); end
    endtask

    task automatic test_wrap();
        clear_queues(); bus.HIT_READY = 1'b1;
        push_rec(make_rec(63, 511, 3, 60, 1'b0, 52'hFFFFFFFFFFFFF, 32'hFFFFFFFF));
        drain(50);
        n_cmp += 2;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", obs_q.size()); end
        else if (obs_tot_q[0] !== 6'd7) begin n_err++; $display("FAIL wrap_tot got %0d want 7", obs_tot_q[0]); end
        if (obs_q.size() == 1 && obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL wrap_rec got %h want %h", obs_q[0], exp_q[0]); end
    endtask

    task automatic test_conf_en();
        logic [111:0] r1, r2;
        clear_queues(); bus.HIT_READY = 1'b1;
        r1 = rand_rec(1'b0); r2 = rand_rec(1'b0);
        push_word(ID, 2'd0, r1[27:0]); push_word(ID, 2'd1, r1[55:28]);
        drain(50);
        CONF_EN = 1'b0;
        part_q.delete(); in_rec = 0;
        push_word(ID, 2'd2, r1[83:56]); push_word(ID, 2'd3, r1[111:84]);
        repeat (4) cycle();
        n_cmp++;
        if (fifo_q.size() != 2) begin n_err++; $display("FAIL en_hold got fifo level %0d want 2", fifo_q.size()); end
        CONF_EN = 1'b1;
        push_rec(r2);
        drain(50);
        n_cmp += 2;
        if (SEQ_ERR_CNT !== 8'(exp_seq)) begin n_err++; $display("FAIL en_seq got %0d want %0d", SEQ_ERR_CNT, exp_seq); end
        if (obs_q.size() != 1 || obs_q[0] !== r2) begin n_err++; $display("FAIL en_rec got %0d records want 1", obs_q.size()); end
    endtask

    task automatic test_random();
        logic [111:0] r;
        logic [1:0] tag, id;
        int mode, k;
        clear_queues();
        CONF_DROP_NOISE = ($urandom_range(0, 1) == 1);
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            r = rand_rec($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 7);
            k = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) begin
                tag = j[1:0]; id = ID;
                if (j == k && mode == 0) id = ID ^ 2'($urandom_range(1, 3));
                if (j == k && mode == 2) tag = 2'($urandom_range(0, 3));
                if (!(j == k && mode == 1)) push_word(id, tag, r[28*j +: 28]);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cycle();
            end
        end
        drain(2000);
        rand_ready = 0; bus.HIT_READY = 1'b1;
        n_cmp += 4;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (SEQ_ERR_CNT !== 8'(exp_seq)) begin n_err++; $display("FAIL rand_seq got %0d want %0d", SEQ_ERR_CNT, exp_seq); end
        if (ID_ERR_CNT !== 8'(exp_id)) begin n_err++; $display("FAIL rand_id got %0d want %0d", ID_ERR_CNT, exp_id); end
        if (DROP_CNT !== 8'(exp_drop)) begin n_err++; $display("FAIL rand_drop got %0d want %0d", DROP_CNT, exp_drop); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp += 2;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_rec[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
            if (obs_tot_q[i] !== ref_tot(exp_q[i])) begin n_err++; $display("FAIL rand_tot[%0d] got %0d want %0d", i, obs_tot_q[i], ref_tot(exp_q[i])); end
        end
        CONF_DROP_NOISE = 1'b0;
    endtask

    task automatic test_saturation();
        clear_queues(); bus.HIT_READY = 1'b1;
        for (int n = 0; n < 300; n++) push_word(ID, 2'd1, 28'(n));
        drain(1000);
        n_cmp += 2;
        if (SEQ_ERR_CNT !== 8'd255) begin n_err++; $display("FAIL sat_seq got %0d want 255", SEQ_ERR_CNT); end
        if (SEQ_ERR_CNT !== 8'(exp_seq)) begin n_err++; $display("FAIL sat_model got %0d want %0d", SEQ_ERR_CNT, exp_seq); end
    endtask

    task automatic test_reset_mid();
        logic [111:0] r1, r2, r3;
        clear_queues(); bus.HIT_READY = 1'b0;
        r1 = rand_rec(1'b0); r2 = rand_rec(1'b0); r3 = rand_rec(1'b0);
        push_rec(r1); push_word(ID, 2'd0, r2[27:0]); push_word(ID, 2'd1, r2[55:28]);
        repeat (10) cycle();
        BUS_RST = 1'b1;
        #1;
        n_cmp += 3;
        if (bus.HIT_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", bus.HIT_VALID); end
        if ({bus.HIT_TOKEN_CNT, bus.HIT_TIMESTAMP, bus.HIT_NOISE, bus.HIT_LE, bus.HIT_TE, bus.HIT_ROW, bus.HIT_COL, bus.HIT_TOT} !== 118'h0) begin
            n_err++; $display("FAIL rstmid_fields got nonzero hit fields");
        end
        if ({SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT} !== 24'h0) begin n_err++; $display("FAIL rstmid_counters got %h want 0", {SEQ_ERR_CNT, ID_ERR_CNT, DROP_CNT}); end
        fifo_q.delete(); fifo_update();
        part_q.delete(); in_rec = 0; exp_seq = 0; exp_id = 0; exp_drop = 0;
        clear_queues();
        @(negedge BUS_CLK); BUS_RST = 1'b0;
        @(posedge BUS_CLK); #1;
        bus.HIT_READY = 1'b1;
        push_rec(r3);
        drain(50);
        n_cmp += 2;
        if (obs_q.size() != 1 || obs_q[0] !== r3) begin n_err++; $display("FAIL rstmid_rec got %0d records want 1", obs_q.size()); end
        if (obs_q.size() == 1 && obs_tot_q[0] !== ref_tot(r3)) begin n_err++; $display("FAIL rstmid_tot got %0d want %0d", obs_tot_q[0], ref_tot(r3)); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_pop_cyc = 0; rd_empty_viol = 0;
        exp_seq = 0; exp_id = 0; exp_drop = 0; in_rec = 0; rand_ready = 0;
        bus.FIFO_EMPTY = 1'b1; bus.FIFO_DATA = 32'h0; bus.HIT_READY = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_tag_error();
        test_id_error();
        test_noise();
        test_wrap();
        test_conf_en();
        test_random();
        test_saturation();
        test_reset_mid();
        n_cmp++;
        if (rd_empty_viol != 0) begin n_err++; $display("FAIL read_while_empty got %0d events want 0", rd_empty_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tjmono_hit_assembler.md
Name: tjmono_hit_assembler

Overview:
- Sits downstream of the TJ-Monopix data receiver's output FIFO.
- Pops 32-bit words in 4-word groups and rebuilds each 112-bit hit record. Each word carries a 2-bit identifier, a 2-bit sequence tag and a 28-bit chunk.
- Checks identifier and tag order, decodes the hit fields and computes ToT.
- Presents one hit per valid/ready handshake to the on-FPGA histogrammer or event builder.

Parameters:
- IDENTIFIER, 2'b00, expected value of FIFO_DATA[31:30]; words with any other value are rejected.

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  asynchronous, active-high reset.
- FIFO_EMPTY  in  1  source FIFO empty. FIFO_DATA is valid whenever this is low (first-word fall-through).
- FIFO_DATA  in  32  source word: [31:30] identifier, [29:28] tag, [27:0] chunk.
- FIFO_READ  out  1  pops the current word. Never asserted while FIFO_EMPTY=1.
- CONF_EN  in  1  enables popping.
- CONF_DROP_NOISE  in  1  discard records whose noise flag is set.
- HIT_VALID  out  1  output record valid.
- HIT_READY  in  1  consumer accepts.
- HIT_COL  out  6  column.
- HIT_ROW  out  9  row.
- HIT_LE  out  6  leading edge.
- HIT_TE  out  6  trailing edge.
- HIT_TOT  out  6  (HIT_TE − HIT_LE) mod 64.
- HIT_NOISE  out  1  possible-noise flag.
- HIT_TIMESTAMP  out  52  token timestamp.
- HIT_TOKEN_CNT  out  32  token counter.
- SEQ_ERR_CNT  out  8  tag-order errors, saturating.
- ID_ERR_CNT  out  8  identifier mismatches, saturating.
- DROP_CNT  out  8  noise records dropped, saturating.

Behaviour:
- Reset (async, BUS_RST=1): all outputs 0, state WAIT_HEAD, assembly buffer cleared.
- Record layout, LSB first: [5:0] col, [14:6] row, [20:15] te, [26:21] le, [27] noise, [79:28] timestamp, [111:80] token_cnt.
- Word order: tag 0 → chunk to [27:0], tag 1 → [55:28], tag 2 → [83:56], tag 3 → [111:84].
- States:
  - WAIT_HEAD: expect tag 0.
  - COLLECT: expect tag = exp_idx, where exp_idx is 1..3.
- Pop condition, FIFO_READ = CONF_EN & ~FIFO_EMPTY & ~stall.
  - stall = word would complete a record (COLLECT, exp_idx=3, tag=3, ID ok) & HIT_VALID & ~HIT_READY.
  - Every popped word is consumed in the same cycle.
- Popped word with ID mismatch:
  - ID_ERR_CNT++.
  - Word dropped; any partial record discarded; state → WAIT_HEAD.
  - When the mismatch occurs in COLLECT, SEQ_ERR_CNT is not also incremented.
- Popped word, ID ok, in WAIT_HEAD:
  - Tag 0: store chunk, exp_idx=1, → COLLECT.
  - Other tag: drop, SEQ_ERR_CNT++, stay in WAIT_HEAD.
- Popped word, ID ok, in COLLECT:
  - Tag = exp_idx: store chunk, exp_idx++.
  - Tag 3 completes the record → WAIT_HEAD.
  - Tag ≠ exp_idx: SEQ_ERR_CNT++ and the partial record is discarded.
    - If that tag is 0, the word starts a new record (exp_idx=1, stay in COLLECT).
    - Otherwise → WAIT_HEAD.
- Completion, with the tag-3 word popped in cycle N:
  - Noise=1 & CONF_DROP_NOISE: DROP_CNT++, HIT_VALID unchanged.
  - Otherwise the output register loads in N and HIT_VALID=1 from N+1. Latency is 1 cycle from the final pop.
- Output register: holds stable while HIT_VALID & ~HIT_READY. It clears on a handshake unless it reloads in the same cycle, which gives back-to-back throughput.
- HIT_TOT is computed combinationally from the registered LE/TE, with 6-bit wrap (e.g. le=60, te=3 → 7).
- CONF_EN deasserted:
  - Popping stops; the partial record is discarded; state → WAIT_HEAD.
  - The output register still drains.
- Counters stick at 255 and clear only on reset.

Decomposition:
- Shared package tjmono_pkg:
  - record field offsets and widths (COL_W=6, ROW_W=9, EDGE_W=6, TS_W=52, TOKCNT_W=32, REC_W=112, CHUNK_W=28);
  - state encodings WAIT_HEAD and COLLECT;
  - tag constants.
- Sub-module sat_cnt8: saturating 8-bit counter with inc input, instantiated three times.

Test Plan:
- Single record: tags 0,1,2,3 carrying col=5, row=300, te=20, le=10, noise=0, ts=0x123456789ABCD, tok=7, with HIT_READY=1 → one HIT_VALID pulse one cycle after the 4th pop. Fields match; HIT_TOT=10; all error counters 0.
- Backpressure: two back-to-back records with HIT_READY=0 → first record is held stable. FIFO_READ drops when the 8th word arrives and the FIFO retains it. Raising HIT_READY drains both in order with no loss.
- Tag error: sequence 0,1,3 then a full valid record → SEQ_ERR_CNT=1; only the valid record is output. Sequence 0,1,0,1,2,3 → SEQ_ERR_CNT=2, one record output.
- Identifier mismatch: IDENTIFIER=2'b01, one word carrying 2'b10 mid-record → ID_ERR_CNT=1; the record is discarded; the next clean record is output.
- Noise filter: record with noise=1 and CONF_DROP_NOISE=1 → no HIT_VALID, DROP_CNT=1. Same record with CONF_DROP_NOISE=0 → output with HIT_NOISE=1.
- Wrap, saturation and reset: le=60, te=3 → HIT_TOT=7. 300 tag errors → SEQ_ERR_CNT=255. BUS_RST asserted mid-record → outputs 0 immediately; the next full record is assembled correctly.
